// File: rtl/m_ext_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared RV32M opcode encoding, controller state type and
//               divide special-case constants.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } m_funct3_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_DIV   = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } m_ctrl_state_t;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/m_ext_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : m_ext_ctrl_if
// Description : Request/response bundle between the M controller and the
//               shared multiplier / iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface m_ext_ctrl_if;
    logic        mul_enable;
    logic        div_enable;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic [2:0]  unit_funct3;
    logic [31:0] mul_result;
    logic [31:0] div_result;
    logic        mul_resp;
    logic        div_resp;

    modport master (
        output mul_enable, div_enable, unit_a, unit_b, unit_funct3,
        input  mul_result, div_result, mul_resp, div_resp
    );

    modport slave (
        input  mul_enable, div_enable, unit_a, unit_b, unit_funct3,
        output mul_result, div_result, mul_resp, div_resp
    );
endinterface
`default_nettype wire

// File: rtl/m_ext_ctrl_special_case.sv
`default_nettype none
// ============================================================================
// Module      : m_special_case
// Description : Combinational detection of RISC-V divide-by-zero and signed
//               overflow, with the architecturally defined result.
// Revision    : 1.0 - initial release
// ============================================================================
module m_special_case
    import rv32i_types::*;
(
    input  wire logic [2:0]  funct3,
    input  wire logic [31:0] a,
    input  wire logic [31:0] b,
    output logic             is_special,
    output logic [31:0]      special_result
);

    m_funct3_t w_op;
    logic      w_b_zero;
    logic      w_ovf;

    assign w_op     = m_funct3_t'(funct3);
    assign w_b_zero = (b == 32'd0);
    assign w_ovf    = (a == INT_MIN) && (b == 32'hFFFF_FFFF);

    always_comb begin
        is_special     = 1'b0;
        special_result = 32'd0;
        case (w_op)
            M_DIV, M_DIVU: begin
                if (w_b_zero) begin
                    is_special     = 1'b1;
                    special_result = DIV_ZERO_Q;
                end else if (w_op == M_DIV && w_ovf) begin
                    is_special     = 1'b1;
                    special_result = INT_MIN;
                end
            end
            M_REM, M_REMU: begin
                // remainder of x/0 is x; remainder of the overflow case is 0
                if (w_b_zero) begin
                    is_special     = 1'b1;
                    special_result = a;
                end else if (w_op == M_REM && w_ovf) begin
                    is_special     = 1'b1;
                    special_result = 32'd0;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/m_ext_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : m_ext_ctrl
// Description : Sequences RV32M instructions onto the shared multiplier and
//               iterative divider and stalls the pipeline until completion.
// Revision    : 1.0 - initial release
// ============================================================================
module m_ext_ctrl
    import rv32i_types::*;
#(
    parameter int MUL_ONLY_LAT = 0
)
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        m_valid,
    input  wire logic [2:0]  funct3,
    input  wire logic [31:0] rs1_data,
    input  wire logic [31:0] rs2_data,
    input  wire logic        stall_in,
    input  wire logic        flush,
    output logic             m_stall,
    output logic [31:0]      m_result,
    output logic             m_result_valid,
    m_ext_ctrl_if.master     m_unit
);

    m_ctrl_state_t r_state;
    m_ctrl_state_t w_state_nxt;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_f3;
    logic [31:0] r_result;
    logic        r_mul_en;
    logic        r_div_en;
    logic        r_drain_div;

    logic        w_accept;
    logic        w_capture;
    logic [31:0] w_cap_val;
    logic        w_m_stall;
    logic        w_mul_done;
    logic        w_is_special;
    logic [31:0] w_special_result;

    m_special_case u_special (
        .funct3         (funct3),
        .a              (rs1_data),
        .b              (rs2_data),
        .is_special     (w_is_special),
        .special_result (w_special_result)
    );

    generate
        if (MUL_ONLY_LAT > 0) begin : g_mul_fixed
            localparam int CNT_W = (MUL_ONLY_LAT > 1) ? $clog2(MUL_ONLY_LAT) : 1;
            localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_ONLY_LAT - 1);
            logic [CNT_W-1:0] r_cnt;

            // keeps counting through DRAIN so a squashed multiply still retires
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_cnt <= CNT_LOAD;
                end else if ((r_state == S_MUL || r_state == S_DRAIN) && r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
            assign w_mul_done = (r_cnt == '0);
        end else begin : g_mul_hs
            assign w_mul_done = m_unit.mul_resp;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_m_stall   = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_cap_val   = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (m_valid && !flush) begin
                    w_accept  = 1'b1;
                    w_m_stall = 1'b1;
                    if (!funct3[2]) begin
                        w_state_nxt = S_MUL;
                    end else if (w_is_special) begin
                        w_state_nxt = S_DONE;
                        w_capture   = 1'b1;
                        w_cap_val   = w_special_result;
                    end else begin
                        w_state_nxt = S_DIV;
                    end
                end
            end
            S_MUL: begin
                w_m_stall = !flush;
                if (flush) begin
                    w_state_nxt = w_mul_done ? S_IDLE : S_DRAIN;
                end else if (w_mul_done) begin
                    w_state_nxt = S_DONE;
                    w_capture   = 1'b1;
                    w_cap_val   = m_unit.mul_result;
                end
            end
            S_DIV: begin
                w_m_stall = !flush;
                if (flush) begin
                    w_state_nxt = m_unit.div_resp ? S_IDLE : S_DRAIN;
                end else if (m_unit.div_resp) begin
                    w_state_nxt = S_DONE;
                    w_capture   = 1'b1;
                    w_cap_val   = m_unit.div_result;
                end
            end
            S_DONE: begin
                if (flush || !stall_in) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                w_m_stall = m_valid && !flush;
                if (r_drain_div ? m_unit.div_resp : w_mul_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // enables follow the next state, so they drop on the resp/flush edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_f3        <= 3'd0;
            r_result    <= 32'd0;
            r_mul_en    <= 1'b0;
            r_div_en    <= 1'b0;
            r_drain_div <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= rs1_data;
                r_b  <= rs2_data;
                r_f3 <= funct3;
            end
            if (w_capture) begin
                r_result <= w_cap_val;
            end
            r_mul_en <= (w_state_nxt == S_MUL);
            r_div_en <= (w_state_nxt == S_DIV);
            if (r_state == S_MUL || r_state == S_DIV) begin
                r_drain_div <= (r_state == S_DIV);
            end
        end
    end

    assign m_stall            = w_m_stall;
    assign m_result           = r_result;
    assign m_result_valid     = (r_state == S_DONE);
    assign m_unit.mul_enable  = r_mul_en;
    assign m_unit.div_enable  = r_div_en;
    assign m_unit.unit_a      = r_a;
    assign m_unit.unit_b      = r_b;
    assign m_unit.unit_funct3 = r_f3;

endmodule
`default_nettype wire

// File: tb/tb_m_ext_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_m_ext_ctrl
// Description : Self-checking bench for m_ext_ctrl with behavioural
//               multiplier/divider units and an RV32M reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_ext_ctrl;

    localparam int DIV_LAT = 33;
    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        stall_in;
    logic        flush;
    logic        m_stall;
    logic [31:0] m_result;
    logic        m_result_valid;

    always #5 clk = ~clk;

    m_ext_ctrl_if bus();

    m_ext_ctrl #(.MUL_ONLY_LAT(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .m_valid        (m_valid),
        .funct3         (funct3),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .stall_in       (stall_in),
        .flush          (flush),
        .m_stall        (m_stall),
        .m_result       (m_result),
        .m_result_valid (m_result_valid),
        .m_unit         (bus)
    );

    int checks = 0;
    int failures = 0;
    int div_starts = 0;
    int mul_starts = 0;
    int div_resps = 0;
    logic        exp_active = 1'b0;
    logic        exp_no_div = 1'b0;
    logic [31:0] exp_res = 32'd0;
    logic        div_resp_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // RV32M semantics in plain 64-bit arithmetic; INT_MIN/-1 falls out naturally
    function automatic logic [31:0] ref_m(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (f[2] && b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: p = sa / sb;
            3'd5: p = ua / ub;
            3'd6: p = sa % sb;
            default: p = ua % ub;
        endcase
        return p[31:0];
    endfunction

    // Divider: busy from start through its resp cycle, so a lingering enable restarts it
    logic        div_busy;
    int          div_cnt;
    logic [31:0] div_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div_busy <= 1'b0;
            div_cnt <= 0;
            div_q <= 32'd0;
            bus.div_resp <= 1'b0;
            bus.div_result <= 32'd0;
        end else begin
            bus.div_resp <= 1'b0;
            if (div_busy) begin
                if (bus.div_resp) begin
                    div_busy <= 1'b0;
                end else if (div_cnt == 1) begin
                    bus.div_resp <= 1'b1;
                    bus.div_result <= div_q;
                    div_resps <= div_resps + 1;
                end else begin
                    div_cnt <= div_cnt - 1;
                end
            end else if (bus.div_enable) begin
                div_busy <= 1'b1;
                div_cnt <= DIV_LAT;
                div_q <= ref_m(bus.unit_funct3, bus.unit_a, bus.unit_b);
                div_starts <= div_starts + 1;
            end
        end
    end

    logic        mul_busy;
    int          mul_cnt;
    logic [31:0] mul_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_busy <= 1'b0;
            mul_cnt <= 0;
            mul_q <= 32'd0;
            bus.mul_resp <= 1'b0;
            bus.mul_result <= 32'd0;
        end else begin
            bus.mul_resp <= 1'b0;
            if (mul_busy) begin
                if (bus.mul_resp) begin
                    mul_busy <= 1'b0;
                end else if (mul_cnt == 1) begin
                    bus.mul_resp <= 1'b1;
                    bus.mul_result <= mul_q;
                end else begin
                    mul_cnt <= mul_cnt - 1;
                end
            end else if (bus.mul_enable) begin
                mul_busy <= 1'b1;
                mul_cnt <= MUL_LAT;
                mul_q <= ref_m(bus.unit_funct3, bus.unit_a, bus.unit_b);
                mul_starts <= mul_starts + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_result_valid) begin
                chk("result_valid_expected", {31'd0, exp_active}, 32'd1);
                if (exp_active) chk("result_value", m_result, exp_res);
            end
            if (exp_active && exp_no_div) chk("no_div_enable", {31'd0, bus.div_enable}, 32'd0);
            if (div_resp_d) chk("div_enable_after_resp", {31'd0, bus.div_enable}, 32'd0);
            div_resp_d <= bus.div_resp;
        end
    end

    task automatic wait_unstall(output int n);
        n = 0;
        while (m_stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("stall_timeout", 32'(n), 32'd0);
    endtask

    task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit, input int stall_cyc);
        int s0;
        int n;
        logic special;
        special = f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        chk({nm, "_model"}, ref_m(f, a, b), lit);
        s0 = div_starts;
        @(posedge clk); #1;
        exp_res = lit;
        exp_active = 1'b1;
        exp_no_div = !f[2] || special;
        m_valid = 1'b1;
        funct3 = f;
        rs1_data = a;
        rs2_data = b;
        @(negedge clk);
        wait_unstall(n);
        chk({nm, "_stall_cycles"}, 32'(n), 32'(stall_cyc));
        chk({nm, "_valid"}, {31'd0, m_result_valid}, 32'd1);
        chk({nm, "_result"}, m_result, lit);
        @(posedge clk); #1;
        m_valid = 1'b0;
        exp_active = 1'b0;
        chk({nm, "_div_starts"}, 32'(div_starts - s0), (f[2] && !special) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        int m0;
        int r0;
        rst = 1'b1;
        m_valid = 1'b0;
        funct3 = 3'd0;
        rs1_data = 32'd0;
        rs2_data = 32'd0;
        stall_in = 1'b0;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {26'd0, m_stall, m_result_valid, bus.mul_enable, bus.div_enable,
            bus.unit_funct3 == 3'd0}, 32'd1);
        chk("reset_result", m_result, 32'd0);
        rst = 1'b0;

        // stall cycles: divide = accept + enable cycle + DIV_LAT + resp cycle
        do_op("div_100_7",    3'd4, 32'd100,        32'd7,          32'd14,         36);
        do_op("rem_m100_7",   3'd6, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  36);
        do_op("remu_100_7",   3'd7, 32'd100,        32'd7,          32'd2,          36);
        do_op("divu_5_0",     3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
        do_op("rem_5_0",      3'd6, 32'd5,          32'd0,          32'd5,          1);
        do_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
        do_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);
        do_op("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  6);

        // flush a divide at cycle 10, then a mul waits out the drain
        s0 = div_starts;
        m0 = mul_starts;
        r0 = div_resps;
        @(posedge clk); #1;
        exp_res = ref_m(3'd4, 32'd1000, 32'd3);
        exp_active = 1'b1;
        exp_no_div = 1'b0;
        m_valid = 1'b1;
        funct3 = 3'd4;
        rs1_data = 32'd1000;
        rs2_data = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        exp_active = 1'b0;
        @(negedge clk);
        chk("flush_stall_drop", {31'd0, m_stall}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        funct3 = 3'd0;
        rs1_data = 32'd3;
        rs2_data = 32'd4;
        exp_res = 32'd12;
        exp_active = 1'b1;
        exp_no_div = 1'b1;
        @(negedge clk);
        chk("drain_holds_new", {29'd0, m_stall, m_result_valid, bus.div_enable}, 32'b100);
        wait_unstall(n);
        chk("drain_mul_stall_cycles", 32'(n), 32'd31);
        chk("drain_mul_valid", {31'd0, m_result_valid}, 32'd1);
        chk("drain_mul_result", m_result, 32'd12);
        chk("drain_div_starts", 32'(div_starts - s0), 32'd1);
        chk("drain_div_resps", 32'(div_resps - r0), 32'd1);
        chk("drain_mul_starts", 32'(mul_starts - m0), 32'd1);
        @(posedge clk); #1;
        m_valid = 1'b0;
        exp_active = 1'b0;

        // result held across stall_in with no relaunch
        s0 = div_starts;
        r0 = div_resps;
        @(posedge clk); #1;
        stall_in = 1'b1;
        exp_res = 32'd2;
        exp_active = 1'b1;
        exp_no_div = 1'b0;
        m_valid = 1'b1;
        funct3 = 3'd7;
        rs1_data = 32'd100;
        rs2_data = 32'd7;
        @(negedge clk);
        wait_unstall(n);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_result", {m_result[30:0], m_result_valid}, {31'd2, 1'b1});
        end
        @(posedge clk); #1;
        stall_in = 1'b0;
        @(posedge clk); #1;
        m_valid = 1'b0;
        exp_active = 1'b0;
        @(negedge clk);
        chk("hold_release", {31'd0, m_result_valid}, 32'd0);
        repeat (40) @(negedge clk);
        chk("hold_div_starts", 32'(div_starts - s0), 32'd1);
        chk("hold_div_resps", 32'(div_resps - r0), 32'd1);

        // asynchronous reset in the middle of a divide
        @(posedge clk); #1;
        exp_res = ref_m(3'd5, 32'd1000, 32'd3);
        exp_active = 1'b1;
        exp_no_div = 1'b0;
        m_valid = 1'b1;
        funct3 = 3'd5;
        rs1_data = 32'd1000;
        rs2_data = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_div_enable", {31'd0, bus.div_enable}, 32'd1);
        #1;
        rst = 1'b1;
        m_valid = 1'b0;
        exp_active = 1'b0;
        #1;
        chk("rst_ctrl", {27'd0, m_stall, m_result_valid, bus.mul_enable, bus.div_enable,
            bus.unit_funct3 != 3'd0}, 32'd0);
        chk("rst_unit_a", bus.unit_a, 32'd0);
        chk("rst_unit_b", bus.unit_b, 32'd0);
        chk("rst_result", m_result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
